// File: rtl/macro_iter_decr.sv
// macro_iter_decr: iterative unsigned decrementer, one 4-bit borrow stage per cycle from the LSB upward.
// Stops at the first nibble that absorbs the borrow. Valid/ready handshakes on both sides.
module macro_iter_decr #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_borrow,
    output logic             o_busy
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IW-1:0] idx_q, idx_d;
    logic borrow_q, borrow_d;
    logic [3:0] nib, nib_dec;
    logic nib_borrow, last;
    // 4-bit decrement stage: borrow out only when the nibble was zero
    assign nib = data_q[4*idx_q +: 4];
    assign {nib_borrow, nib_dec} = {1'b0, nib} - 5'd1;
    assign last = idx_q == IW'(NIBBLES - 1);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            data_q   <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
        end
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_valid) state_d = BUSY;
            BUSY:    if (!nib_borrow || last) state_d = DONE;
            DONE:    if (o_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        data_d   = data_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        if (state_q == IDLE && i_valid) begin
            data_d = i_data;
            idx_d  = '0;
        end else if (state_q == BUSY) begin
            data_d[4*idx_q +: 4] = nib_dec;
            if (!nib_borrow) borrow_d = 1'b0;
            else if (last) borrow_d = 1'b1;
            else idx_d = idx_q + 1'b1;
        end
    end
    always_comb begin
        i_ready = state_q == IDLE;
        o_busy  = state_q == BUSY;
        o_valid = state_q == DONE;
    end
    assign o_data   = data_q;
    assign o_borrow = borrow_q;
endmodule

// File: tb/tb_macro_iter_decr.sv
// tb_macro_iter_decr: scoreboard bench for the nibble-serial decrementer at WIDTH=16 and WIDTH=4.
module tb_macro_iter_decr;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic resetn;
    logic i_valid16, i_ready16, o_valid16, o_ready16, o_borrow16, o_busy16;
    logic [15:0] i_data16, o_data16;
    logic i_valid4, i_ready4, o_valid4, o_ready4, o_borrow4, o_busy4;
    logic [3:0] i_data4, o_data4;

    macro_iter_decr #(.WIDTH(16)) dut16 (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid16), .i_ready(i_ready16), .i_data(i_data16),
        .o_valid(o_valid16), .o_ready(o_ready16), .o_data(o_data16),
        .o_borrow(o_borrow16), .o_busy(o_busy16)
    );
    macro_iter_decr #(.WIDTH(4)) dut4 (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid4), .i_ready(i_ready4), .i_data(i_data4),
        .o_valid(o_valid4), .o_ready(o_ready4), .o_data(o_data4),
        .o_borrow(o_borrow4), .o_busy(o_busy4)
    );

    typedef struct {
        logic [15:0] data;
        logic        borrow;
        int          k;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    function automatic int k_of(input logic [15:0] d, input int nib);
        for (int i = 0; i < nib; i++)
            if (d[4*i +: 4] != 4'h0) return i + 1;
        return nib;
    endfunction

    // drives one operand into the 16-bit DUT and counts cycles until o_valid
    task automatic issue16(input logic [15:0] d, output int lat, output int busy);
        int w = 0;
        while (!i_ready16 && w < 50) begin @(posedge clk); #1; w++; end
        i_valid16 = 1'b1;
        i_data16  = d;
        @(posedge clk); #1;
        i_valid16 = 1'b0;
        sb.push_back('{d - 16'd1, d == 16'h0, k_of(d, 4)});
        lat = 0;
        busy = 0;
        while (!o_valid16 && lat < 20) begin
            busy += int'(o_busy16);
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic issue4(input logic [3:0] d, output int lat);
        int w = 0;
        logic [3:0] q;
        q = d - 4'd1;
        while (!i_ready4 && w < 50) begin @(posedge clk); #1; w++; end
        i_valid4 = 1'b1;
        i_data4  = d;
        @(posedge clk); #1;
        i_valid4 = 1'b0;
        sb.push_back('{{12'h0, q}, d == 4'h0, k_of({12'h0, d}, 1)});
        lat = 0;
        while (!o_valid4 && lat < 20) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        i_valid16 = 1'b0; i_data16 = 16'h0; o_ready16 = 1'b1;
        i_valid4 = 1'b0; i_data4 = 4'h0; o_ready4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (i_ready16 !== 1'b1) begin failures++; $display("FAIL reset_i_ready got=%b exp=1", i_ready16); end
        checks++; if (o_valid16 !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b exp=0", o_valid16); end
        checks++; if (o_busy16 !== 1'b0) begin failures++; $display("FAIL reset_o_busy got=%b exp=0", o_busy16); end
        checks++; if (o_borrow16 !== 1'b0) begin failures++; $display("FAIL reset_o_borrow got=%b exp=0", o_borrow16); end
        checks++; if (o_data16 !== 16'h0) begin failures++; $display("FAIL reset_o_data got=%h exp=0000", o_data16); end
        checks++; if (i_ready4 !== 1'b1 || o_valid4 !== 1'b0) begin failures++; $display("FAIL reset_w4 got=%b%b exp=10", i_ready4, o_valid4); end
        resetn = 1'b1;
        @(posedge clk); #1;
        checks++; if (i_ready16 !== 1'b1) begin failures++; $display("FAIL release_i_ready got=%b exp=1", i_ready16); end
    endtask

    task automatic test_directed;
        logic [15:0] vec [5] = '{16'h0001, 16'h0100, 16'h1000, 16'h0000, 16'hFFFF};
        int lat, busy;
        exp_t e;
        o_ready16 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue16(vec[i], lat, busy);
            e = sb.pop_front();
            checks++; if (o_data16 !== e.data) begin failures++; $display("FAIL dir_data d=%h got=%h exp=%h", vec[i], o_data16, e.data); end
            checks++; if (o_borrow16 !== e.borrow) begin failures++; $display("FAIL dir_borrow d=%h got=%b exp=%b", vec[i], o_borrow16, e.borrow); end
            checks++; if (lat != e.k) begin failures++; $display("FAIL dir_latency d=%h got=%0d exp=%0d", vec[i], lat, e.k); end
            checks++; if (busy != e.k) begin failures++; $display("FAIL dir_busy_cycles d=%h got=%0d exp=%0d", vec[i], busy, e.k); end
            @(posedge clk); #1;
            checks++; if (i_ready16 !== 1'b1 || o_valid16 !== 1'b0) begin failures++; $display("FAIL dir_return_idle d=%h got=%b%b exp=10", vec[i], i_ready16, o_valid16); end
        end
    endtask

    task automatic test_backpressure;
        int lat, busy;
        exp_t e;
        o_ready16 = 1'b0;
        issue16(16'h0030, lat, busy);
        e = sb.pop_front();
        checks++; if (lat != e.k) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", lat, e.k); end
        for (int c = 0; c < 5; c++) begin
            checks++; if (o_valid16 !== 1'b1 || i_ready16 !== 1'b0) begin failures++; $display("FAIL bp_hold c=%0d got=%b%b exp=10", c, o_valid16, i_ready16); end
            checks++; if (o_data16 !== e.data || o_borrow16 !== e.borrow) begin failures++; $display("FAIL bp_data c=%0d got=%h/%b exp=%h/%b", c, o_data16, o_borrow16, e.data, e.borrow); end
            i_valid16 = (c == 1 || c == 2);
            i_data16  = 16'h1234;
            @(posedge clk); #1;
        end
        i_valid16 = 1'b0;
        o_ready16 = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_valid16 !== 1'b0 || i_ready16 !== 1'b1 || o_busy16 !== 1'b0) begin failures++; $display("FAIL bp_release got=%b%b%b exp=010", o_valid16, i_ready16, o_busy16); end
        issue16(16'h5678, lat, busy);
        e = sb.pop_front();
        checks++; if (o_data16 !== e.data || lat != e.k) begin failures++; $display("FAIL bp_next got=%h/%0d exp=%h/%0d", o_data16, lat, e.data, e.k); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat, busy;
        exp_t e;
        o_ready16 = 1'b1;
        i_valid16 = 1'b1;
        i_data16  = 16'h0000;
        @(posedge clk); #1;
        i_valid16 = 1'b0;
        @(posedge clk); #1;
        checks++; if (o_busy16 !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_before got=%b exp=1", o_busy16); end
        resetn = 1'b0;
        #1;
        checks++; if (o_busy16 !== 1'b0 || i_ready16 !== 1'b1 || o_valid16 !== 1'b0) begin failures++; $display("FAIL rst_mid_async got=%b%b%b exp=010", o_busy16, i_ready16, o_valid16); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++; if (o_valid16 !== 1'b0) begin failures++; $display("FAIL rst_mid_no_valid c=%0d got=%b exp=0", c, o_valid16); end
        end
        resetn = 1'b1;
        @(posedge clk); #1;
        issue16(16'h0002, lat, busy);
        e = sb.pop_front();
        checks++; if (o_data16 !== e.data || o_borrow16 !== e.borrow || lat != e.k) begin failures++; $display("FAIL rst_mid_after got=%h/%b/%0d exp=%h/%b/%0d", o_data16, o_borrow16, lat, e.data, e.borrow, e.k); end
        @(posedge clk); #1;
    endtask

    task automatic test_random16;
        int lat, busy, stall, sh;
        logic [31:0] m;
        logic [15:0] d;
        exp_t e;
        for (int n = 0; n < 40; n++) begin
            sh = $urandom_range(0, 4);
            m = (32'd1 << (4 * sh)) - 32'd1;
            d = 16'($urandom) & ~m[15:0];
            o_ready16 = 1'($urandom_range(0, 1));
            issue16(d, lat, busy);
            e = sb.pop_front();
            checks++; if (o_data16 !== e.data || o_borrow16 !== e.borrow) begin failures++; $display("FAIL rnd16_result d=%h got=%h/%b exp=%h/%b", d, o_data16, o_borrow16, e.data, e.borrow); end
            checks++; if (lat != e.k) begin failures++; $display("FAIL rnd16_latency d=%h got=%0d exp=%0d", d, lat, e.k); end
            stall = o_ready16 ? 0 : $urandom_range(1, 3);
            repeat (stall) begin @(posedge clk); #1; end
            if (stall > 0) begin
                checks++; if (o_valid16 !== 1'b1 || o_data16 !== e.data) begin failures++; $display("FAIL rnd16_stall d=%h got=%b/%h exp=1/%h", d, o_valid16, o_data16, e.data); end
            end
            o_ready16 = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random4;
        int lat;
        logic [3:0] d;
        exp_t e;
        for (int n = 0; n < 24; n++) begin
            d = (n < 16) ? 4'(n) : 4'($urandom);
            o_ready4 = 1'($urandom_range(0, 1));
            issue4(d, lat);
            e = sb.pop_front();
            checks++; if ({12'h0, o_data4} !== e.data || o_borrow4 !== e.borrow) begin failures++; $display("FAIL rnd4_result d=%h got=%h/%b exp=%h/%b", d, o_data4, o_borrow4, e.data[3:0], e.borrow); end
            checks++; if (lat != e.k) begin failures++; $display("FAIL rnd4_latency d=%h got=%0d exp=%0d", d, lat, e.k); end
            if (!o_ready4) begin
                @(posedge clk); #1;
                checks++; if (o_valid4 !== 1'b1 || i_ready4 !== 1'b0) begin failures++; $display("FAIL rnd4_stall d=%h got=%b%b exp=10", d, o_valid4, i_ready4); end
            end
            o_ready4 = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random16();
        test_random4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/macro_iter_decr.md
Name: macro_iter_decr

Overview:
- Iterative multi-nibble unsigned decrementer: computes d - 1 for a WIDTH-bit operand using one internal 4-bit decrement ROM stage (4-bit in, 4-bit out, borrow out), processing one nibble per cycle from LSB upward.
- Stops at the first nibble that produces no borrow.
- Valid/ready on both sides; feeds wide counters and timers that need a decrement without a WIDTH-bit carry chain.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and >= 4.
- NIBBLES, WIDTH/4, derived; not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- i_valid  input  1  operand valid.
- i_ready  output  1  block can accept an operand; equals (state == IDLE).
- i_data  input  WIDTH  operand.
- o_valid  output  1  result valid.
- o_ready  input  1  consumer accepts result.
- o_data  output  WIDTH  result, (i_data - 1) mod 2^WIDTH.
- o_borrow  output  1  1 iff operand was 0 (underflow).
- o_busy  output  1  state == BUSY.

Behaviour:
- States: IDLE, BUSY, DONE. Internal registers:
  - data[WIDTH-1:0]
  - idx (clog2(NIBBLES) bits, min 1)
  - borrow
- Reset (resetn low, asynchronous): state=IDLE, data=0, idx=0, borrow=0. Outputs: o_valid=0, o_borrow=0, o_data=0, o_busy=0, i_ready=1. Inputs are ignored while resetn is low.
- IDLE, on i_valid && i_ready at edge E0:
  - data <= i_data, idx <= 0, state <= BUSY.
  - No other IDLE transitions.
- BUSY, at each edge:
  - nibble n = data[4*idx +: 4] goes through the decrement stage, giving q and c; data[4*idx +: 4] <= q.
  - If c==0: state <= DONE, borrow <= 0.
  - Else if idx==NIBBLES-1: state <= DONE, borrow <= 1.
  - Else: idx <= idx+1.
  - Nibbles above idx are never modified.
- Latency:
  - k = (index of lowest nonzero nibble of i_data) + 1, or NIBBLES if i_data==0.
  - o_valid rises after edge Ek, i.e. k cycles after the accept edge.
  - Range 1..NIBBLES.
- DONE:
  - o_valid=1; o_data=data and o_borrow=borrow held stable while o_ready=0.
  - On o_valid && o_ready: state <= IDLE, o_valid drops next cycle.
  - i_ready=0 in DONE regardless of o_ready (no same-cycle pass-through).
  - Minimum issue interval is k+2 cycles.
- i_valid in BUSY or DONE is ignored: no capture, no effect on the in-flight result.
- o_data is undefined-but-stable outside DONE: it equals the data register, and the bench checks it only when o_valid=1.
- Wrap-around: operand 0 gives all-ones result with o_borrow=1. Operand 2^WIDTH-1 gives 2^WIDTH-2 with k=1.
- Reset mid-BUSY or mid-DONE: immediate return to reset values; the in-flight result is discarded and no o_valid is emitted.
- WIDTH=4: idx is 1 bit held at 0, k is always 1.
- No combinational path from i_valid or i_data to o_* outputs, or from o_ready to i_ready.

Test Plan:
- WIDTH=16, i_data=0x0001, o_ready=1 -> o_valid 1 cycle after accept, o_data=0x0000, o_borrow=0; i_ready back to 1 the cycle after the o handshake.
- i_data=0x0100 -> o_busy high 3 cycles, o_data=0x00FF, o_borrow=0. i_data=0x1000 -> 4 cycles, o_data=0x0FFF.
- i_data=0x0000 -> 4 BUSY cycles, o_data=0xFFFF, o_borrow=1. i_data=0xFFFF -> 1 cycle, o_data=0xFFFE, o_borrow=0.
- Backpressure: i_data=0x0030, o_ready held 0 for 5 cycles -> o_valid stays 1, o_data=0x002F stable, i_ready=0 throughout. i_valid pulsed with 0x1234 during the stall is not captured. After o_ready=1, the next accepted operand is processed correctly.
- Reset: accept 0x0000, deassert resetn during the 2nd BUSY cycle -> o_busy=0, i_ready=1, o_valid=0 immediately. After release, 0x0002 -> 0x0001.
- Randomized sweep (WIDTH=16 and WIDTH=4, random o_ready): every result equals (d-1) mod 2^WIDTH, o_borrow==(d==0), latency == k as defined above.
